kb_emu: RTL

Matrix-keypad emulator: the far end of the 3×4 keypad scan interface, sitting where the physical keypad would be. It queues 4-bit key codes from a host, then answers the scanner's row-select outputs De by pulling the correct column line of Co low, for a programmable press time followed by a release gap. Benches and demo builds use it to type digit strings into the keypad/7-segment entry logic without hardware.

---
 rtl/kb_emu_if.sv | 25 ++
 rtl/kb_emu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/kb_emu_if.sv
// Host/scanner-facing signal bundle of the keypad emulator.
// The master side is the host plus scanner; the slave side is kb_emu.
interface kb_emu_if;
  logic [2:0] De;
  logic [2:0] Co;
  logic       Wr;
  logic [3:0] Din;
  logic       Full;
  logic       Empty;
  logic [3:0] Count;
  logic       Busy;
  logic       Done;
  logic       Ovf;
  logic       Err;

  modport master (
    output De, Wr, Din,
    input  Co, Full, Empty, Count, Busy, Done, Ovf, Err
  );

  modport slave (
    input  De, Wr, Din,
    output Co, Full, Empty, Count, Busy, Done, Ovf, Err
  );
endinterface

// File: rtl/kb_emu.sv
// 3x4 matrix-keypad emulator: queues host key codes and answers the scanner's
// row selects by pulling one column low for PRESS_CYC, then releases for GAP_CYC.
module kb_emu #(
  parameter int unsigned PRESS_CYC = 131072,
  parameter int unsigned GAP_CYC   = 131072,
  parameter int unsigned CW        = 20
) (
  input  logic    Clk10M,
  input  logic    Clr,
  kb_emu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, PRESS, GAP} state_t;

  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  logic [3:0]    r_mem [8];
  logic [2:0]    r_wp;
  logic [2:0]    r_rp;
  logic [3:0]    r_count;
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_row;
  logic [2:0]    r_pat;
  logic [2:0]    r_co;
  logic          r_ovf;
  logic          r_err;

  logic          w_valid;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_done;
  logic          w_cnt_clr;
  logic [3:0]    w_head;
  logic [3:0]    w_idx;
  logic [2:0]    w_row;
  logic [1:0]    w_col;
  logic [2:0]    w_pat;

  assign w_valid = (bus.Din <= 4'd11);
  assign w_full  = (r_count == 4'd8);
  assign w_empty = (r_count == 4'd0);
  // A pop in the same cycle frees a slot, so a push is taken even while Full.
  assign w_push  = bus.Wr && w_valid && (!w_full || w_pop);

  always_ff @(posedge Clk10M) begin
    if (w_push) begin
      r_mem[r_wp] <= bus.Din;
    end
  end

  always_ff @(posedge Clk10M or posedge Clr) begin
    if (Clr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 3'd1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 3'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      r_err <= bus.Wr && !w_valid;
      r_ovf <= bus.Wr && w_valid && w_full && !w_pop;
    end
  end

  // Head-of-queue decode: row/column of the key about to be loaded.
  always_comb begin
    w_head = r_mem[r_rp];
    w_idx  = w_head - 4'd1;
    w_row  = 3'd0;
    w_col  = 2'd0;
    case (w_head)
      4'd0:  begin w_row = 3'd3; w_col = 2'd1; end
      4'd10: begin w_row = 3'd3; w_col = 2'd0; end
      4'd11: begin w_row = 3'd3; w_col = 2'd2; end
      default: begin
        w_row = 3'(w_idx / 4'd3);
        w_col = 2'(w_idx % 4'd3);
      end
    endcase
    case (w_col)
      2'd0:    w_pat = 3'b011;
      2'd1:    w_pat = 3'b101;
      default: w_pat = 3'b110;
    endcase
  end

  always_ff @(posedge Clk10M or posedge Clr) begin
    if (Clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_pat   <= 3'b111;
    end else begin
      r_state <= w_next;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_pop) begin
        r_row <= w_row;
        r_pat <= w_pat;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_done    = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_empty) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_pop     = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = PRESS;
      end
      PRESS: begin
        if (r_cnt == PRESS_LAST) begin
          w_cnt_clr = 1'b1;
          w_next    = GAP;
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_done    = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = w_empty ? IDLE : LOAD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk10M or posedge Clr) begin
    if (Clr) begin
      r_co <= 3'b111;
    end else begin
      r_co <= ((r_state == PRESS) && (bus.De == r_row)) ? r_pat : 3'b111;
    end
  end

  assign bus.Co    = r_co;
  assign bus.Full  = w_full;
  assign bus.Empty = w_empty;
  assign bus.Count = r_count;
  assign bus.Busy  = (r_state != IDLE);
  assign bus.Done  = w_done;
  assign bus.Ovf   = r_ovf;
  assign bus.Err   = r_err;

endmodule
